// File: rtl/shift_add_sequencer.sv
// shift_add_sequencer
//   Control and accumulate stage of a sequential unsigned shift-and-add
//   multiplier. This block drives an external right-shift multiplier register
//   and takes in that register's serial LSB, one multiplier bit per cycle. It
//   keeps the multiplicand and a 2W-bit accumulator, and registers the product.
//
// Ports
//   clk              in   1    rising-edge clock
//   reset            in   1    asynchronous, active-low reset
//   start            in   1    multiply request; sampled only in IDLE
//   multiplicand     in   W    operand A; captured on an accepted start
//   multiplierBit    in   1    serial LSB from the multiplier shift register
//   loadMultiplier   out  1    shift register load; high only in LOAD
//   shiftMultiplier  out  1    shift register shift; high only in RUN
//   busy             out  1    high in LOAD, RUN and DONE
//   done             out  1    one-cycle pulse in DONE
//   product          out  2W   registered A*B; held until the next result
//   state_dbg        out  2    current FSM state (debug observation)
//
// Handshake: a rising clock edge with start==1 while busy==0 accepts one
// operation. start is ignored while busy==1 and is never queued. The result
// is valid on product from the cycle in which done is high, and it stays
// there until the next result or a reset.

module shift_add_sequencer #(
  parameter int WORD_LENGTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [WORD_LENGTH-1:0]     multiplicand,
  input  logic                       multiplierBit,
  output logic                       loadMultiplier,
  output logic                       shiftMultiplier,
  output logic                       busy,
  output logic                       done,
  output logic [2*WORD_LENGTH-1:0]   product,
  output logic [1:0]                 state_dbg
);

  localparam int W  = WORD_LENGTH;
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [2*W-1:0]  acc;
  logic [2*W-1:0]  mcand;
  logic [2*W-1:0]  acc_next;
  logic [CW-1:0]   count;

  // The partial-product sum for this RUN cycle. It is used both for the
  // accumulator and for the final product, so the last bit is not lost.
  assign acc_next = acc + (multiplierBit ? mcand : '0);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = LOAD;
      LOAD:    next_state = RUN;
      RUN:     if (count == LAST_COUNT) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Moore outputs
  always_comb begin
    loadMultiplier  = 1'b0;
    shiftMultiplier = 1'b0;
    busy            = 1'b0;
    done            = 1'b0;
    case (state)
      LOAD: begin
        loadMultiplier = 1'b1;
        busy           = 1'b1;
      end
      RUN: begin
        shiftMultiplier = 1'b1;
        busy            = 1'b1;
      end
      DONE: begin
        done = 1'b1;
        busy = 1'b1;
      end
      default: ;
    endcase
  end

  assign state_dbg = state;

  // Datapath: operand capture, accumulate, and product register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc     <= '0;
      mcand   <= '0;
      count   <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand <= {{W{1'b0}}, multiplicand};
            acc   <= '0;
            count <= '0;
          end
        end
        RUN: begin
          acc   <= acc_next;
          mcand <= mcand << 1;
          count <= count + CW'(1);
          if (count == LAST_COUNT) begin
            product <= acc_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_sequencer.sv
// Testbench for shift_add_sequencer (W=4). It includes a behavioural
// right-shift multiplier register with load priority and serial LSB out.
// A timeline model predicts every output on every cycle from the time an
// operation was accepted. Directed scenarios add hand-computed expectations.

module tb_shift_add_sequencer;

  localparam int W = 4;

  logic           clk;
  logic           reset;
  logic           start;
  logic [W-1:0]   multiplicand;
  logic [W-1:0]   b_in;
  logic           multiplier_bit;
  logic           load_m;
  logic           shift_m;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;
  logic [1:0]     state_dbg;
  logic [W-1:0]   sr;

  int chk_cnt;
  int pass_cnt;

  // Model state: rel is the number of edges since acceptance, or -1 when idle
  int             rel;
  int             m_a;
  int             m_b;
  logic [2*W-1:0] exp_prod;

  shift_add_sequencer #(.WORD_LENGTH(W)) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .multiplicand    (multiplicand),
    .multiplierBit   (multiplier_bit),
    .loadMultiplier  (load_m),
    .shiftMultiplier (shift_m),
    .busy            (busy),
    .done            (done),
    .product         (product),
    .state_dbg       (state_dbg)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiplier shift register: load has priority; serial input tied to 0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sr <= '0;
    else if (load_m) sr <= b_in;
    else if (shift_m) sr <= {1'b0, sr[W-1:1]};
  end
  assign multiplier_bit = sr[0];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Per-cycle model and compare
  task automatic monitor();
    forever begin
      @(posedge clk);
      if (!reset) begin
        rel = -1;
        exp_prod = '0;
      end else if (rel == -1 || rel == W + 2) begin
        if (start) begin
          rel = 0;
          m_a = int'(multiplicand);
        end else begin
          rel = -1;
        end
      end else begin
        if (rel == 0) m_b = int'(b_in);
        rel++;
        if (rel == W + 1) exp_prod = (2*W)'(m_a * m_b);
      end
      #1;
      check("cyc_load",  32'(load_m),  32'(rel == 0));
      check("cyc_shift", 32'(shift_m), 32'(rel >= 1 && rel <= W));
      check("cyc_done",  32'(done),    32'(rel == W + 1));
      check("cyc_busy",  32'(busy),    32'(rel >= 0 && rel <= W + 1));
      check("cyc_prod",  32'(product), 32'(exp_prod));
    end
  endtask

  // Drivers
  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        break;
      end
    end
    if (lat == 0) check("done_timeout", 32'd0, 32'd1);
  endtask

  // Latency counts negedges from the start-drive negedge to the first done
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
    int l;
    @(negedge clk);
    start = 1'b1;
    multiplicand = a;
    b_in = b;
    @(negedge clk);
    start = 1'b0;
    multiplicand = W'($urandom_range(0, 15));
    wait_done(l);
    lat = (l == 0) ? 0 : l + 1;
  endtask

  int lat;
  int dones;
  int d1;
  int d2;
  int idle_cnt;
  logic [W-1:0] ta [5];
  logic [W-1:0] tb [5];
  logic [7:0]   tp [5];

  initial begin
    chk_cnt = 0;
    pass_cnt = 0;
    rel = -1;
    m_a = 0;
    m_b = 0;
    exp_prod = '0;
    reset = 1'b0;
    start = 1'b0;
    multiplicand = '0;
    b_in = '0;
    fork
      monitor();
    join_none

    // Reset values
    #1;
    check("rst_load",  32'(load_m),  32'd0);
    check("rst_shift", 32'(shift_m), 32'd0);
    check("rst_busy",  32'(busy),    32'd0);
    check("rst_done",  32'(done),    32'd0);
    check("rst_prod",  32'(product), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // 1. 13*11
    run_op(4'd13, 4'd11, lat);
    check("t1_latency", 32'(lat), 32'd6);
    check("t1_prod", 32'(product), 32'd143);
    @(negedge clk);
    check("t1_done_low", 32'(done), 32'd0);
    check("t1_hold", 32'(product), 32'd143);

    // 2. Corner operands
    ta = '{4'd15, 4'd0, 4'd9, 4'd1, 4'd8};
    tb = '{4'd15, 4'd9, 4'd0, 4'd1, 4'd8};
    tp = '{8'd225, 8'd0, 8'd0, 8'd1, 8'd64};
    for (int i = 0; i < 5; i++) begin
      run_op(ta[i], tb[i], lat);
      check("t2_prod", 32'(product), 32'(tp[i]));
      check("t2_latency", 32'(lat), 32'd6);
    end

    // 3. start pulsed during RUN is ignored
    @(negedge clk);
    start = 1'b1;
    multiplicand = 4'd6;
    b_in = 4'd7;
    dones = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i <= 6) check("t3_busy", 32'(busy), 32'd1);
      if (i == 6) check("t3_done_at6", 32'(done), 32'd1);
      if (done) dones++;
      start = (i == 3);
    end
    check("t3_dones", 32'(dones), 32'd1);
    check("t3_prod", 32'(product), 32'd42);

    // 4. start held high: back-to-back operations
    @(negedge clk);
    start = 1'b1;
    multiplicand = 4'd3;
    b_in = 4'd5;
    d1 = 0;
    d2 = 0;
    idle_cnt = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (done) begin
        if (d1 == 0) begin
          d1 = i;
          check("t4_prod1", 32'(product), 32'd15);
          multiplicand = 4'd7;
          b_in = 4'd2;
        end else begin
          d2 = i;
          check("t4_prod2", 32'(product), 32'd14);
          start = 1'b0;
          break;
        end
      end else if (d1 != 0 && !busy) begin
        idle_cnt++;
      end
    end
    check("t4_first_done", 32'(d1), 32'd6);
    check("t4_period", 32'(d2 - d1), 32'd7);
    check("t4_idle_cycles", 32'(idle_cnt), 32'd1);
    repeat (3) @(negedge clk);
    check("t4_no_restart", 32'(busy), 32'd0);

    // 5. Reset during the third RUN cycle
    @(negedge clk);
    start = 1'b1;
    multiplicand = 4'd5;
    b_in = 4'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("t5_load",  32'(load_m),  32'd0);
    check("t5_shift", 32'(shift_m), 32'd0);
    check("t5_busy",  32'(busy),    32'd0);
    check("t5_done",  32'(done),    32'd0);
    check("t5_prod",  32'(product), 32'd0);
    dones = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) dones++;
    end
    reset = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("t5_no_done", 32'(dones), 32'd0);
    run_op(4'd2, 4'd3, lat);
    check("t5_prod_after", 32'(product), 32'd6);

    // 6. Exhaustive sweep
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_op(W'(a), W'(b), lat);
        check("t6_prod", 32'(product), 32'(a * b));
      end
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
